mic_lclk_lock_ctrl: RTL and testbench
=====================================

# mic_lclk_lock_ctrl

Lock controller for the mic-clock domain. It measures the tclk period in mic_clk cycles, checks each measurement against a programmable window, and sequences an acquire/lock/hold state machine. It also detects missing tclk and raises a sticky fault. It sits beside the mic_clk period counter and gates downstream use of mic-side timing on a qualified lock indication.

## Interface
- CW, 16: width of the period counter, window bounds and measurement.
- LOCK_N, 4: consecutive in-window measurements required to enter LOCKED (1..15).
- UNLOCK_N, 2: consecutive out-of-window measurements in HOLD that drop lock (1..15).
- TIMEOUT, 16'hFFF0: pos_cnt value that declares tclk missing (must be < 2^CW-1).

- mic_clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable; 0 forces IDLE.
- tclk  in  1  asynchronous reference clock to be measured.
- win_lo  in  CW  lowest acceptable measurement, inclusive; quasi-static.
- win_hi  in  CW  highest acceptable measurement, inclusive; quasi-static.
- fault_clr  in  1  single-cycle pulse that clears fault.
- meas_cnt  out  CW  last measurement (period − 1).
- meas_vld  out  1  one-cycle pulse; meas_cnt updated this cycle.
- lock  out  1  1 in LOCKED and HOLD.
- fault  out  1  sticky lock-loss/timeout flag.
- state  out  2  IDLE=0, ACQ=1, LOCKED=2, HOLD=3.

## Operation
- Synchronizer: tclk_r[1:0] <= {tclk_r[0], tclk}. Edge strobe tclk_pos = ~tclk_r[1] & tclk_r[0].
- pos_cnt (CW bits): cleared on tclk_pos or on timeout; otherwise incremented. It is held at 0 in IDLE.
- armed flag: cleared in IDLE and on timeout. It is set by the first tclk_pos after that. A tclk_pos with armed=0 only arms: no meas_vld and no evaluation, because the interval is partial.
- Measurement: tclk_pos with armed=1 produces the following at the next edge:
  - meas_cnt <= pos_cnt
  - meas_vld <= 1
  - the evaluation below
- Good measurement: win_lo <= pos_cnt <= win_hi. Bad otherwise. If win_lo > win_hi, every measurement is bad.
- Timeout: pos_cnt == TIMEOUT with no tclk_pos in that cycle. The event clears pos_cnt and armed and produces no meas_vld. If tclk_pos and the timeout condition coincide, tclk_pos wins.
- good_cnt and bad_cnt are 4-bit consecutive counters. A bad measurement clears good_cnt; a good measurement clears bad_cnt.
- State machine:
  - IDLE:
    - Entered on reset or whenever en=0, from any state.
    - Clears good_cnt, bad_cnt, armed, meas_cnt and fault.
    - en=1 -> ACQ.
  - ACQ:
    - Good measurement: good_cnt+1. When it reaches LOCK_N -> LOCKED, with good_cnt and bad_cnt cleared.
    - Bad measurement: good_cnt=0.
    - Timeout: good_cnt=0, stay in ACQ.
  - LOCKED:
    - Good measurement: stay.
    - Bad measurement: bad_cnt=1; -> HOLD, or directly -> ACQ with fault=1 if UNLOCK_N=1.
    - Timeout: -> ACQ with fault=1.
  - HOLD:
    - Good measurement: -> LOCKED, bad_cnt=0.
    - Bad measurement: bad_cnt+1. When it reaches UNLOCK_N -> ACQ, with fault=1 and counters cleared.
    - Timeout: -> ACQ with fault=1.
- fault:
  - Set on any lock-loss transition to ACQ.
  - Cleared by fault_clr or in IDLE. If fault_clr and a set event coincide, the set wins.
- lock = (state == LOCKED) | (state == HOLD), registered.

## Timing
- Reset (rst=0): every output is 0, state=IDLE, and all internal registers are 0.
- Latency from a tclk rising edge to its tclk_pos strobe is 2–3 mic_clk cycles, depending on synchronizer phase.
- meas_vld, meas_cnt, state and lock update on the mic_clk edge after the tclk_pos cycle. lock rises on the same edge as the LOCK_N-th good meas_vld.
- For a steady tclk period of P mic_clk cycles, meas_cnt = P−1.
- meas_vld is never asserted on two consecutive cycles; it needs P >= 2.
- en falling: state=IDLE and lock=0 on the next edge. Any measurement in flight is discarded.
- en rising: ACQ on the next edge. The first valid measurement arrives at the second tclk_pos after that.
- Timeout fires TIMEOUT+1 cycles after the last clear of pos_cnt.
- rst asserted mid-operation: outputs go to reset values immediately (asynchronously).

## Test plan
- Lock acquire: rst, en=1, window 95..105, tclk period 100 -> first edge only arms; meas_cnt=99 on each later meas_vld; lock=1 and state=2 on the 4th meas_vld; fault=0.
- Boundaries: window 99..99 with periods 100, 99, 101 -> measurements 99 good; 98 and 100 bad.
- Lock loss via HOLD: from LOCKED, one period of 120 -> state=3 with lock=1. A following 100 returns state=2. Two consecutive 120s -> state=1, lock=0, fault=1.
- Fault handling: fault_clr pulse -> fault=0 next edge. fault_clr coinciding with a lock-loss event -> fault stays 1.
- Timeout: from LOCKED, stop tclk -> after TIMEOUT+1 cycles, state=1, fault=1, and no meas_vld. Restart tclk -> first edge arms only, then 4 good measurements relock.
- Enable/reset mid-run: en=0 while LOCKED -> state=0, lock=0, meas_cnt=0 next edge. rst pulse during ACQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/mic_lclk_lock_ctrl.sv
// mic_lclk_lock_ctrl: measures the tclk period in mic_clk cycles, qualifies each
// measurement against [win_lo, win_hi] and runs the IDLE/ACQ/LOCKED/HOLD lock
// sequencer. A missing tclk (pos_cnt reaching TIMEOUT) is treated as a lost
// reference. The fault flag is sticky and records lock loss.
//
// Output handshake: meas_vld is a one-cycle valid pulse with no ready. meas_cnt
// is updated on the same edge and holds until the next measurement or IDLE.
// The consumer must take the value in the cycle where meas_vld is high.
module mic_lclk_lock_ctrl #(
  parameter int CW       = 16,
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2,
  parameter int TIMEOUT  = 'hFFF0
) (
  input  logic          mic_clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tclk,
  input  logic [CW-1:0] win_lo,
  input  logic [CW-1:0] win_hi,
  input  logic          fault_clr,
  output logic [CW-1:0] meas_cnt,
  output logic          meas_vld,
  output logic          lock,
  output logic          fault,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0]    LOCK_TGT   = 4'(LOCK_N);
  localparam logic [3:0]    UNLOCK_TGT = 4'(UNLOCK_N);
  localparam logic [CW-1:0] TMO        = CW'(TIMEOUT);

  state_t        state_q;
  logic [1:0]    tclk_r;
  logic [CW-1:0] pos_cnt;
  logic          armed;
  logic [3:0]    good_cnt;
  logic [3:0]    bad_cnt;

  logic tclk_pos;
  logic in_win;
  logic timeout;
  logic meas_evt;

  // tclk_pos marks the cycle after a synchronized rising edge of tclk.
  // The first edge after arming only starts the interval. A timeout is
  // suppressed when an edge arrives in the same cycle.
  assign tclk_pos = ~tclk_r[1] & tclk_r[0];
  assign in_win   = (pos_cnt >= win_lo) && (pos_cnt <= win_hi);
  assign timeout  = (pos_cnt == TMO) && !tclk_pos;
  assign meas_evt = tclk_pos && armed;
  assign state    = state_q;

  // Two-stage synchronizer for the asynchronous reference clock
  always_ff @(posedge mic_clk or negedge rst) begin
    if (!rst) begin
      tclk_r <= 2'b00;
    end else begin
      tclk_r <= {tclk_r[0], tclk};
    end
  end

  // Period counter, measurement capture and lock sequencer
  always_ff @(posedge mic_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pos_cnt  <= '0;
      armed    <= 1'b0;
      meas_cnt <= '0;
      meas_vld <= 1'b0;
      good_cnt <= 4'd0;
      bad_cnt  <= 4'd0;
      lock     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      meas_vld <= 1'b0;
      if (!en || state_q == IDLE) begin
        // Disabled or idle: everything is cleared, and an enabled idle moves to ACQ
        state_q  <= en ? ACQ : IDLE;
        pos_cnt  <= '0;
        armed    <= 1'b0;
        meas_cnt <= '0;
        good_cnt <= 4'd0;
        bad_cnt  <= 4'd0;
        lock     <= 1'b0;
        fault    <= 1'b0;
      end else begin
        // A clear request loses to any fault set event later in this block
        if (fault_clr) fault <= 1'b0;

        if (tclk_pos) begin
          pos_cnt <= '0;
          armed   <= 1'b1;
        end else if (timeout) begin
          pos_cnt <= '0;
          armed   <= 1'b0;
        end else begin
          pos_cnt <= pos_cnt + 1'b1;
        end

        if (meas_evt) begin
          meas_cnt <= pos_cnt;
          meas_vld <= 1'b1;
          case (state_q)
            ACQ: begin
              if (in_win) begin
                bad_cnt <= 4'd0;
                if (good_cnt + 4'd1 == LOCK_TGT) begin
                  state_q  <= LOCKED;
                  lock     <= 1'b1;
                  good_cnt <= 4'd0;
                end else begin
                  good_cnt <= good_cnt + 4'd1;
                end
              end else begin
                good_cnt <= 4'd0;
              end
            end
            LOCKED: begin
              if (!in_win) begin
                good_cnt <= 4'd0;
                if (UNLOCK_TGT == 4'd1) begin
                  state_q <= ACQ;
                  lock    <= 1'b0;
                  fault   <= 1'b1;
                  bad_cnt <= 4'd0;
                end else begin
                  state_q <= HOLD;
                  bad_cnt <= 4'd1;
                end
              end else begin
                bad_cnt <= 4'd0;
              end
            end
            HOLD: begin
              if (in_win) begin
                state_q <= LOCKED;
                bad_cnt <= 4'd0;
              end else if (bad_cnt + 4'd1 == UNLOCK_TGT) begin
                state_q  <= ACQ;
                lock     <= 1'b0;
                fault    <= 1'b1;
                good_cnt <= 4'd0;
                bad_cnt  <= 4'd0;
              end else begin
                good_cnt <= 4'd0;
                bad_cnt  <= bad_cnt + 4'd1;
              end
            end
            default: ;
          endcase
        end else if (timeout) begin
          // A missing reference restarts acquisition. It is a lock loss only when locked.
          good_cnt <= 4'd0;
          bad_cnt  <= 4'd0;
          if (state_q == LOCKED || state_q == HOLD) begin
            state_q <= ACQ;
            lock    <= 1'b0;
            fault   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mic_lclk_lock_ctrl.sv
// Bench for mic_lclk_lock_ctrl. A cycle-indexed reference model predicts every
// output after every mic_clk edge. Directed lock/boundary/fault/timeout/enable/reset
// scenarios are followed by a randomized period/window/enable phase.
module tb_mic_lclk_lock_ctrl;

  localparam int CW       = 16;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 2;
  localparam int TMO      = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          tclk;
  logic [CW-1:0] win_lo;
  logic [CW-1:0] win_hi;
  logic          fault_clr;
  logic [CW-1:0] meas_cnt;
  logic          meas_vld;
  logic          lock;
  logic          fault;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fails  = 0;

  mic_lclk_lock_ctrl #(
    .CW(CW), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .TIMEOUT(TMO)
  ) dut (
    .mic_clk(clk), .rst(rst), .en(en), .tclk(tclk),
    .win_lo(win_lo), .win_hi(win_hi), .fault_clr(fault_clr),
    .meas_cnt(meas_cnt), .meas_vld(meas_vld), .lock(lock),
    .fault(fault), .state(state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d required %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is counted in mic_clk edges. ref_edge is the edge after which the
  // period count restarts at zero, so the interval seen at edge n is n-1-ref_edge.
  int m_state, m_good, m_bad, m_meas, m_ref, edge_n;
  bit m_armed, m_vld, m_fault, s0, s1;

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_meas = 0; m_ref = edge_n;
    m_armed = 0; m_vld = 0; m_fault = 0; s0 = 0; s1 = 0;
  endtask

  task automatic lose_lock();
    m_state = 1; m_fault = 1; m_good = 0; m_bad = 0;
  endtask

  task automatic judge(input bit good);
    case (m_state)
      1: if (good) begin
           m_bad = 0;
           if (m_good + 1 == LOCK_N) begin m_state = 2; m_good = 0; end
           else m_good++;
         end else m_good = 0;
      2: if (!good) begin
           m_good = 0;
           if (UNLOCK_N == 1) lose_lock();
           else begin m_state = 3; m_bad = 1; end
         end else m_bad = 0;
      3: if (good) begin m_state = 2; m_bad = 0; end
         else if (m_bad + 1 == UNLOCK_N) lose_lock();
         else begin m_good = 0; m_bad++; end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    int  elapsed;
    bit  rise;
    edge_n++;
    if (!rst) begin
      model_reset();
      return;
    end
    rise = s0 && !s1;
    s1 = s0;
    s0 = tclk;
    m_vld = 0;
    if (!en || m_state == 0) begin
      m_state = en ? 1 : 0;
      m_good = 0; m_bad = 0; m_armed = 0; m_meas = 0; m_fault = 0; m_ref = edge_n;
    end else begin
      elapsed = edge_n - 1 - m_ref;
      if (fault_clr) m_fault = 0;
      if (rise) begin
        m_ref = edge_n;
        if (m_armed) begin
          m_meas = elapsed;
          m_vld  = 1;
          judge(elapsed >= int'(win_lo) && elapsed <= int'(win_hi));
        end else m_armed = 1;
      end else if (elapsed == TMO) begin
        m_ref = edge_n;
        m_armed = 0;
        if (m_state == 2 || m_state == 3) lose_lock();
        else m_good = 0;
      end
    end
  endtask

  // ---------------- drivers ----------------
  // One mic_clk edge: advance the model, then compare all outputs just after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("state", 32'(state), 32'(m_state));
    check("lock", 32'(lock), 32'((m_state == 2) || (m_state == 3)));
    check("fault", 32'(fault), 32'(m_fault));
    check("meas_vld", 32'(meas_vld), 32'(m_vld));
    check("meas_cnt", 32'(meas_cnt), 32'(m_meas));
  endtask

  // One full tclk period of p cycles starting with a rising edge.
  task automatic run_period(input int p, input bit fclr_rise, input bit rand_clr);
    for (int i = 0; i < p; i++) begin
      tclk = (i < p / 2);
      fault_clr = (fclr_rise && i == 1) || (rand_clr && $urandom_range(0, 63) == 0);
      tick();
    end
    fault_clr = 1'b0;
  endtask

  task automatic set_win(input int lo, input int hi);
    win_lo = CW'(lo);
    win_hi = CW'(hi);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bnd[7];
    edge_n = 0;
    model_reset();
    rst = 1'b0; en = 1'b0; tclk = 1'b0; fault_clr = 1'b0;
    set_win(95, 105);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Lock acquire at P=100 within 95..105
    en = 1'b1;
    repeat (6) run_period(100, 0, 0);
    check("acq_state", 32'(state), 32'd2);
    check("acq_lock", 32'(lock), 32'd1);
    check("acq_meas", 32'(meas_cnt), 32'd99);
    check("acq_fault", 32'(fault), 32'd0);

    // Window boundaries 99..99 with HOLD excursions and a two-bad lock loss
    set_win(99, 99);
    bnd = '{100, 100, 99, 100, 101, 101, 100};
    for (int i = 0; i < 7; i++) begin
      run_period(bnd[i], 0, 0);
      if (i == 3) check("bnd_hold_state", 32'(state), 32'd3);
      if (i == 4) check("bnd_relock_state", 32'(state), 32'd2);
    end
    check("bnd_loss_state", 32'(state), 32'd1);
    check("bnd_loss_fault", 32'(fault), 32'd1);

    // fault_clr pulse, then fault_clr coinciding with a lock loss
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_fault", 32'(fault), 32'd0);
    set_win(95, 105);
    repeat (6) run_period(100, 0, 0);
    run_period(120, 1, 0);
    check("hold_lock", 32'(lock), 32'd1);
    run_period(120, 1, 0);
    run_period(100, 1, 0);
    check("clr_vs_set_fault", 32'(fault), 32'd1);
    check("clr_vs_set_state", 32'(state), 32'd1);

    // Timeout from LOCKED, then relock after tclk restarts
    repeat (6) run_period(100, 0, 0);
    check("pre_tmo_lock", 32'(lock), 32'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tclk = 1'b0;
    repeat (TMO + 60) tick();
    check("tmo_state", 32'(state), 32'd1);
    check("tmo_fault", 32'(fault), 32'd1);
    repeat (6) run_period(100, 0, 0);
    check("tmo_relock", 32'(state), 32'd2);

    // en=0 while LOCKED
    en = 1'b0;
    tick();
    check("en_off_state", 32'(state), 32'd0);
    check("en_off_lock", 32'(lock), 32'd0);
    check("en_off_meas", 32'(meas_cnt), 32'd0);
    en = 1'b1;
    repeat (3) run_period(100, 0, 0);

    // Asynchronous reset while in ACQ
    #2 rst = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_meas", 32'(meas_cnt), 32'd0);
    check("rst_vld_lock_fault", {29'd0, meas_vld, lock, fault}, 32'd0);
    model_reset();
    #3 rst = 1'b1;
    repeat (6) run_period(100, 0, 0);

    // Randomized periods, windows, fault clears and enable drops
    for (int k = 0; k < 30; k++) begin
      if (k % 7 == 3) set_win(105, 95);
      else set_win($urandom_range(94, 100), $urandom_range(98, 106));
      if ($urandom_range(0, 7) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        en = 1'b1;
      end
      repeat ($urandom_range(1, 4)) run_period($urandom_range(92, 110), 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
